// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_unit
//  Description : Pipeline sequencer for the 5-stage core. Detects load-use and
//                control hazards and drives F/D/E stall/flush enables and the
//                E-stage operand forwarding selects. A shadow copy of E/M/W
//                destination state is fed from D-stage decode outputs. It also
//                keeps saturating stall/flush perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
   parameter int AW    = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    Rs1D,
   input  logic [AW-1:0]    Rs2D,
   input  logic [AW-1:0]    RdD,
   input  logic             RegWriteD,
   input  logic [1:0]       ResultSrcD,
   input  logic             PCSrcE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam logic [1:0]       C_RESULT_LOAD = 2'b01;
   localparam logic [1:0]       C_FWD_RD1     = 2'b00;
   localparam logic [1:0]       C_FWD_W       = 2'b01;
   localparam logic [1:0]       C_FWD_M       = 2'b10;
   localparam logic [CNT_W-1:0] C_CNT_MAX     = '1;
   localparam logic [CNT_W-1:0] C_CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   // Shadow E stage
   logic [AW-1:0]    rs1_e_q, rs1_e_d;
   logic [AW-1:0]    rs2_e_q, rs2_e_d;
   logic [AW-1:0]    rd_e_q, rd_e_d;
   logic             reg_write_e_q, reg_write_e_d;
   logic             load_e_q, load_e_d;
   // Shadow M and W stages
   logic [AW-1:0]    rd_m_q, rd_m_d;
   logic             reg_write_m_q, reg_write_m_d;
   logic [AW-1:0]    rd_w_q, rd_w_d;
   logic             reg_write_w_q, reg_write_w_d;
   // Perf counters
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic             lw_stall;

   // Forward select for one E-stage source; M is younger so it wins over W.
   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs_e,
                                          input logic [AW-1:0] rd_m, input logic wr_m,
                                          input logic [AW-1:0] rd_w, input logic wr_w);
      logic [1:0] sel;
      sel = C_FWD_RD1;
      if (wr_m && (rd_m != '0) && (rd_m == rs_e)) begin
         sel = C_FWD_M;
      end else if (wr_w && (rd_w != '0) && (rd_w == rs_e)) begin
         sel = C_FWD_W;
      end
      return sel;
   endfunction

   // Hazard detection and stall/flush/forward outputs, combinational from shadow state and D inputs
   always_comb begin
      lw_stall  = load_e_q & reg_write_e_q & (rd_e_q != '0) &
                  ((rd_e_q == Rs1D) | (rd_e_q == Rs2D));
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      if (PCSrcE) begin
         // Redirect squashes D and E; holding F/D would keep a wrong-path instruction
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else begin
         StallF = lw_stall;
         StallD = lw_stall;
         FlushE = lw_stall;
      end
      ForwardAE = fwd_sel(rs1_e_q, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
      ForwardBE = fwd_sel(rs2_e_q, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
      StallCnt  = stall_cnt_q;
      FlushCnt  = flush_cnt_q;
   end

   // Next shadow state: E takes D or a bubble, M and W always advance; counters saturate
   always_comb begin
      rs1_e_d       = Rs1D;
      rs2_e_d       = Rs2D;
      rd_e_d        = RdD;
      reg_write_e_d = RegWriteD;
      load_e_d      = (ResultSrcD == C_RESULT_LOAD);
      if (FlushE) begin
         rs1_e_d       = '0;
         rs2_e_d       = '0;
         rd_e_d        = '0;
         reg_write_e_d = 1'b0;
         load_e_d      = 1'b0;
      end
      rd_m_d        = rd_e_q;
      reg_write_m_d = reg_write_e_q;
      rd_w_d        = rd_m_q;
      reg_write_w_d = reg_write_m_q;

      stall_cnt_d = stall_cnt_q;
      if (lw_stall && (stall_cnt_q != C_CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + C_CNT_ONE;
      end
      flush_cnt_d = flush_cnt_q;
      if (PCSrcE && (flush_cnt_q != C_CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + C_CNT_ONE;
      end
   end

   // Shadow state and counter registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_e_q       <= '0;
         rs2_e_q       <= '0;
         rd_e_q        <= '0;
         reg_write_e_q <= 1'b0;
         load_e_q      <= 1'b0;
         rd_m_q        <= '0;
         reg_write_m_q <= 1'b0;
         rd_w_q        <= '0;
         reg_write_w_q <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         rs1_e_q       <= rs1_e_d;
         rs2_e_q       <= rs2_e_d;
         rd_e_q        <= rd_e_d;
         reg_write_e_q <= reg_write_e_d;
         load_e_q      <= load_e_d;
         rd_m_q        <= rd_m_d;
         reg_write_m_q <= reg_write_m_d;
         rd_w_q        <= rd_w_d;
         reg_write_w_q <= reg_write_w_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_unit
//  Description : Self-checking bench for hazard_unit (CNT_W=4). Table of
//                instruction-sequence vectors with hand-derived outputs, plus
//                saturation and asynchronous-reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

   localparam int AW    = 5;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [AW-1:0]    Rs1D, Rs2D, RdD;
   logic             RegWriteD;
   logic [1:0]       ResultSrcD;
   logic             PCSrcE;
   logic             StallF, StallD, FlushD, FlushE;
   logic [1:0]       ForwardAE, ForwardBE;
   logic [CNT_W-1:0] StallCnt, FlushCnt;

   // {StallF,StallD,FlushD,FlushE}, ForwardAE, ForwardBE, StallCnt, FlushCnt
   typedef struct packed {
      logic [3:0] ctl;
      logic [1:0] fa;
      logic [1:0] fb;
      logic [3:0] sc;
      logic [3:0] fc;
   } out_t;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       rw;
      logic [1:0] rsrc;
      logic       pc;
      out_t       exp;
   } vec_t;

   vec_t vecs[$];
   out_t sb[$];
   out_t act;
   int   errors = 0;
   int   checks = 0;

   hazard_unit #(.AW(AW), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Rs1D       (Rs1D),
      .Rs2D       (Rs2D),
      .RdD        (RdD),
      .RegWriteD  (RegWriteD),
      .ResultSrcD (ResultSrcD),
      .PCSrcE     (PCSrcE),
      .StallF     (StallF),
      .StallD     (StallD),
      .FlushD     (FlushD),
      .FlushE     (FlushE),
      .ForwardAE  (ForwardAE),
      .ForwardBE  (ForwardBE),
      .StallCnt   (StallCnt),
      .FlushCnt   (FlushCnt)
   );

   always #5 clk = ~clk;

   assign act = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCnt, FlushCnt};

   function automatic vec_t mk(input int rs1, input int rs2, input int rd, input int rw,
                               input int rsrc, input int pc, input int ctl,
                               input int fa, input int fb, input int sc, input int fc);
      vec_t v;
      v.rs1     = rs1[4:0];
      v.rs2     = rs2[4:0];
      v.rd      = rd[4:0];
      v.rw      = rw[0];
      v.rsrc    = rsrc[1:0];
      v.pc      = pc[0];
      v.exp.ctl = ctl[3:0];
      v.exp.fa  = fa[1:0];
      v.exp.fb  = fb[1:0];
      v.exp.sc  = sc[3:0];
      v.exp.fc  = fc[3:0];
      return v;
   endfunction

   task automatic drive(input int rs1, input int rs2, input int rd, input int rw,
                        input int rsrc, input int pc);
      Rs1D       = rs1[4:0];
      Rs2D       = rs2[4:0];
      RdD        = rd[4:0];
      RegWriteD  = rw[0];
      ResultSrcD = rsrc[1:0];
      PCSrcE     = pc[0];
   endtask

   task automatic check(input string name, input out_t got, input out_t want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got ctl=%b fa=%b fb=%b sc=%0d fc=%0d, want ctl=%b fa=%b fb=%b sc=%0d fc=%0d",
                  name, got.ctl, got.fa, got.fb, got.sc, got.fc,
                  want.ctl, want.fa, want.fb, want.sc, want.fc);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);

      //            rs1 rs2 rd rw rsrc pc  ctl      fa     fb     sc fc
      vecs.push_back(mk( 2, 0, 5, 1, 1, 0, 4'b0000, 2'b00, 2'b00, 0, 0)); // lw x5
      vecs.push_back(mk( 5, 1, 6, 1, 0, 0, 4'b1101, 2'b00, 2'b00, 0, 0)); // add x6,x5,x1: load-use
      vecs.push_back(mk( 5, 1, 6, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 0)); // held, E bubble
      vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 4'b0000, 2'b01, 2'b00, 1, 0)); // add in E, lw in W
      vecs.push_back(mk( 1, 0, 3, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 0)); // addi x3
      vecs.push_back(mk( 3, 3, 4, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 0)); // add x4,x3,x3
      vecs.push_back(mk( 0, 0, 7, 1, 0, 0, 4'b0000, 2'b10, 2'b10, 1, 0)); // EX->EX both srcs
      vecs.push_back(mk( 0, 0, 7, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 0)); // addi x7
      vecs.push_back(mk( 7, 0, 8, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 0)); // add x8,x7,x0
      vecs.push_back(mk( 0, 0, 0, 1, 0, 0, 4'b0000, 2'b10, 2'b00, 1, 0)); // x7 in M and W: M wins
      vecs.push_back(mk( 0, 0, 0, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 0)); // addi x0
      vecs.push_back(mk( 0, 0, 9, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 0)); // x0 in M
      vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 0)); // x0 in M and W: no fwd
      vecs.push_back(mk( 1, 0, 0, 1, 1, 0, 4'b0000, 2'b00, 2'b00, 1, 0)); // lw x0
      vecs.push_back(mk( 0, 0,10, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 0)); // reads x0 after lw x0
      vecs.push_back(mk( 0, 0,11, 1, 1, 1, 4'b0011, 2'b00, 2'b00, 1, 0)); // redirect, lw x11 in D
      vecs.push_back(mk(11, 0,12, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1, 1)); // squashed lw: no stall
      vecs.push_back(mk( 0, 0,13, 1, 1, 0, 4'b0000, 2'b00, 2'b00, 1, 1)); // lw x13
      vecs.push_back(mk(13,13,14, 1, 0, 1, 4'b0011, 2'b00, 2'b00, 1, 1)); // load-use + redirect
      vecs.push_back(mk( 0, 0,15, 1, 1, 0, 4'b0000, 2'b00, 2'b00, 2, 2)); // lw x15
      vecs.push_back(mk( 1,15,16, 1, 0, 0, 4'b1101, 2'b00, 2'b00, 2, 2)); // load-use via Rs2D
      vecs.push_back(mk( 1,15,16, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 3, 2)); // held
      vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b01, 3, 2)); // Rs2E from W
      vecs.push_back(mk( 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 3, 2)); // idle

      #2;
      check("reset_state", act, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(int'(vecs[i].rs1), int'(vecs[i].rs2), int'(vecs[i].rd), int'(vecs[i].rw),
               int'(vecs[i].rsrc), int'(vecs[i].pc));
         sb.push_back(vecs[i].exp);
         @(negedge clk);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL vec%0d: scoreboard empty, got %h want an entry", i, act);
         end else begin
            out_t w;
            w = sb.pop_front();
            check($sformatf("vec%0d", i), act, w);
         end
         @(posedge clk);
         #1;
      end

      // Repeated load-use pairs: 20 stalls on top of 3 saturate a 4-bit counter
      for (int i = 0; i < 40; i++) begin
         drive(5, 5, 5, 1, 1, 0);
         @(posedge clk);
         #1;
      end
      // 20 redirect cycles on top of 2
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 0, 0, 1);
         @(posedge clk);
         #1;
      end
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("saturate", act, {4'b0000, 2'b00, 2'b00, 4'd15, 4'd15});

      // Reset in the middle of a load-use stall
      drive(0, 0, 5, 1, 1, 0);
      @(posedge clk);
      #1;
      drive(5, 0, 6, 1, 0, 0);
      #1;
      check("pre_reset_stall", act, {4'b1101, 2'b00, 2'b00, 4'd15, 4'd15});
      rst_n = 1'b0;
      #1;
      check("async_reset", act, '0);
      #1;
      rst_n = 1'b1;
      #1;
      check("post_reset_d", act, '0);
      @(posedge clk);
      #1;
      check("post_reset_e", act, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
